disp_queue: RTL and testbench

DISP_QUEUE -- requirements
Module: disp_queue

---
 rtl/disp_queue.sv | 122 ++++++++++++
 tb/tb_disp_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/disp_queue.sv
// Dispatch queue between decode and rename/dispatch: circular buffer with
// compacting multi-port enqueue and in-order multi-port dequeue.
package disp_queue_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [15:0] uop;
  } decinfo_t;
endpackage

module disp_queue
  import disp_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned INPORT  = 2,
  parameter int unsigned OUTPORT = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_squash_vld,
  output logic                         o_enq_rdy,
  input  logic     [INPORT-1:0]        i_enq_vld,
  input  decinfo_t [INPORT-1:0]        i_enq_inst,
  output logic     [OUTPORT-1:0]       o_deq_vld,
  output decinfo_t [OUTPORT-1:0]       o_deq_inst,
  input  logic     [OUTPORT-1:0]       i_deq_rdy,
  output logic     [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = $clog2(INPORT + 1);
  localparam int unsigned DW = $clog2(OUTPORT + 1);

  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  decinfo_t          mem_q [DEPTH];

  logic [INPORT-1:0] enq_gate;
  logic [EW-1:0]     enq_num;
  logic [IW-1:0]     wr_idx [INPORT];
  logic [DW-1:0]     deq_num;
  logic              deq_stop;
  logic              full_c;
  logic              empty_c;

  assign full_c    = (head_q[IW-1:0] == tail_q[IW-1:0]) && (head_q[IW] != tail_q[IW]);
  assign empty_c   = (head_q == tail_q);
  assign o_enq_rdy = (CW'(DEPTH) - count_q) >= CW'(INPORT);
  assign o_count   = count_q;
  assign enq_gate  = i_enq_vld & {INPORT{o_enq_rdy}};

  // Valid ports pack into consecutive slots from tail, lowest port first.
  always_comb begin : enq_slots
    enq_num = '0;
    for (int p = 0; p < INPORT; p++) begin
      wr_idx[p] = tail_q[IW-1:0] + IW'(enq_num);
      enq_num   = enq_num + EW'(enq_gate[p]);
    end
  end

  always_comb begin : deq_view
    for (int k = 0; k < OUTPORT; k++) begin
      o_deq_vld[k]  = count_q > CW'(k);
      o_deq_inst[k] = mem_q[head_q[IW-1:0] + IW'(k)];
    end
  end

  // Only the leading run of handshaking ports retires.
  always_comb begin : deq_count
    deq_num  = '0;
    deq_stop = 1'b0;
    for (int k = 0; k < OUTPORT; k++) begin
      if (!deq_stop && o_deq_vld[k] && i_deq_rdy[k]) begin
        deq_num = deq_num + DW'(1);
      end else begin
        deq_stop = 1'b1;
      end
    end
  end

  always_comb begin : next_state
    head_d  = head_q + PW'(deq_num);
    tail_d  = tail_q + PW'(enq_num);
    count_d = count_q + CW'(enq_num) - CW'(deq_num);
    if (i_squash_vld) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin : state_reg
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload array carries no reset; pointers alone define what is live.
  always_ff @(posedge clk) begin : payload_write
    if (!i_squash_vld) begin
      for (int p = 0; p < INPORT; p++) begin
        if (enq_gate[p]) begin
          mem_q[wr_idx[p]] <= i_enq_inst[p];
        end
      end
    end
  end

  a_full_cnt:  assert property (@(posedge clk) disable iff (!rst)
                                full_c == (count_q == CW'(DEPTH)));
  a_empty_cnt: assert property (@(posedge clk) disable iff (!rst)
                                empty_c == (count_q == '0));

endmodule

// File: tb/tb_disp_queue.sv
// Directed bench for disp_queue: driver pushes accepted payloads into a
// scoreboard queue, a negedge monitor pops and compares the dequeue view.
module tb_disp_queue;
  import disp_queue_pkg::*;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned INPORT  = 2;
  localparam int unsigned OUTPORT = 2;
  localparam int unsigned CW      = $clog2(DEPTH + 1);

  logic                 clk;
  logic                 rst;
  logic                 squash;
  logic                 enq_rdy;
  logic     [1:0]       enq_vld;
  decinfo_t [1:0]       enq_inst;
  logic     [1:0]       deq_vld;
  decinfo_t [1:0]       deq_inst;
  logic     [1:0]       deq_rdy;
  logic     [CW-1:0]    count;

  decinfo_t sb [$];
  int       m_cnt;
  int       n_chk;
  int       n_fail;
  int       tag;
  decinfo_t last_pay [2];
  decinfo_t f0, f1;

  disp_queue #(.DEPTH(DEPTH), .INPORT(INPORT), .OUTPORT(OUTPORT)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_squash_vld (squash),
    .o_enq_rdy    (enq_rdy),
    .i_enq_vld    (enq_vld),
    .i_enq_inst   (enq_inst),
    .o_deq_vld    (deq_vld),
    .o_deq_inst   (deq_inst),
    .i_deq_rdy    (deq_rdy),
    .o_count      (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic decinfo_t mk(input int t);
    decinfo_t d;
    d.pc  = 32'h1000 + 32'(t) * 32'd4;
    d.uop = 16'(t) ^ 16'hA500;
    return d;
  endfunction

  // Apply one cycle of stimulus; record accepted payloads as expected output.
  task automatic drive(input logic [1:0] v, input logic [1:0] r, input logic sq);
    decinfo_t pay [2];
    bit       acc;
    for (int p = 0; p < 2; p++) begin
      pay[p] = mk(tag);
      tag++;
    end
    enq_vld     = v;
    deq_rdy     = r;
    squash      = sq;
    enq_inst[0] = pay[0];
    enq_inst[1] = pay[1];
    last_pay    = pay;
    acc = rst && !sq && (m_cnt <= int'(DEPTH - INPORT));
    if (acc) begin
      for (int p = 0; p < 2; p++) begin
        if (v[p]) sb.push_back(pay[p]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    int dn;
    bit stop;
    if (!rst) begin
      sb.delete();
      m_cnt = 0;
    end
    chk("mon_count", 64'(count), 64'(m_cnt));
    chk("mon_enq_rdy", 64'(enq_rdy), 64'(m_cnt <= int'(DEPTH - INPORT)));
    for (int k = 0; k < OUTPORT; k++) begin
      chk("mon_deq_vld", 64'(deq_vld[k]), 64'(m_cnt > k));
      if (m_cnt > k) chk("mon_deq_inst", 64'(deq_inst[k]), 64'(sb[k]));
    end
    if (rst) begin
      dn   = 0;
      stop = 1'b0;
      for (int k = 0; k < OUTPORT; k++) begin
        if (!stop && (m_cnt > k) && deq_rdy[k]) dn++;
        else stop = 1'b1;
      end
      repeat (dn) void'(sb.pop_front());
      if (squash) sb.delete();
    end
    m_cnt = sb.size();
  end

  initial begin
    rst      = 1'b0;
    squash   = 1'b0;
    enq_vld  = '0;
    deq_rdy  = '0;
    enq_inst = '0;
    tag      = 1;
    m_cnt    = 0;
    n_chk    = 0;
    n_fail   = 0;
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_deq_vld", 64'(deq_vld), 64'd0);
    chk("rst_enq_rdy", 64'(enq_rdy), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Fill with full groups
    drive(2'b11, 2'b00, 1'b0);
    f0 = last_pay[0];
    f1 = last_pay[1];
    chk("fill_cnt2", 64'(count), 64'd2);
    chk("fill_rdy2", 64'(enq_rdy), 64'd1);
    chk("fill_head", 64'(deq_inst[0]), 64'(f0));
    drive(2'b11, 2'b00, 1'b0);
    chk("fill_cnt4", 64'(count), 64'd4);
    drive(2'b11, 2'b00, 1'b0);
    chk("fill_cnt6", 64'(count), 64'd6);
    chk("fill_rdy6", 64'(enq_rdy), 64'd1);
    drive(2'b11, 2'b00, 1'b0);
    chk("fill_cnt8", 64'(count), 64'd8);
    chk("fill_rdy8", 64'(enq_rdy), 64'd0);
    chk("fill_inst1", 64'(deq_inst[1]), 64'(f1));

    // Drop while not ready, then double dequeue
    drive(2'b00, 2'b01, 1'b0);
    chk("deq1_cnt7", 64'(count), 64'd7);
    chk("cnt7_rdy", 64'(enq_rdy), 64'd0);
    chk("deq1_head", 64'(deq_inst[0]), 64'(f1));
    drive(2'b11, 2'b00, 1'b0);
    chk("drop_cnt7", 64'(count), 64'd7);
    drive(2'b00, 2'b11, 1'b0);
    chk("deq2_cnt5", 64'(count), 64'd5);
    drive(2'b00, 2'b11, 1'b0);
    chk("deq2_cnt3", 64'(count), 64'd3);

    drive(2'b01, 2'b11, 1'b0);
    chk("simul_cnt2", 64'(count), 64'd2);
    drive(2'b11, 2'b00, 1'b0);
    chk("refill_cnt4", 64'(count), 64'd4);
    drive(2'b00, 2'b10, 1'b0);
    chk("rdy10_cnt4", 64'(count), 64'd4);
    drive(2'b00, 2'b11, 1'b0);
    drive(2'b00, 2'b11, 1'b0);
    chk("drain_cnt0", 64'(count), 64'd0);
    chk("drain_vld0", 64'(deq_vld), 64'd0);

    // Non-prefix enqueue pattern
    drive(2'b10, 2'b00, 1'b0);
    chk("port1_cnt1", 64'(count), 64'd1);
    chk("port1_inst", 64'(deq_inst[0]), 64'(last_pay[1]));
    drive(2'b00, 2'b01, 1'b0);
    chk("port1_cnt0", 64'(count), 64'd0);

    // Random traffic to wrap the pointers
    repeat (40) drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0);

    // Squash with enqueue active
    drive(2'b11, 2'b00, 1'b0);
    drive(2'b11, 2'b11, 1'b1);
    chk("squash_cnt0", 64'(count), 64'd0);
    chk("squash_vld0", 64'(deq_vld), 64'd0);
    drive(2'b01, 2'b00, 1'b0);
    chk("post_sq_cnt1", 64'(count), 64'd1);
    chk("post_sq_inst", 64'(deq_inst[0]), 64'(last_pay[0]));
    drive(2'b11, 2'b00, 1'b0);
    chk("pre_rst_cnt3", 64'(count), 64'd3);

    // Asynchronous reset mid-operation
    #2;
    rst     = 1'b0;
    enq_vld = '0;
    deq_rdy = '0;
    #1;
    chk("arst_cnt0", 64'(count), 64'd0);
    chk("arst_vld0", 64'(deq_vld), 64'd0);
    chk("arst_rdy1", 64'(enq_rdy), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(2'b11, 2'b00, 1'b0);
    chk("after_rst_cnt2", 64'(count), 64'd2);
    chk("after_rst_inst", 64'(deq_inst[0]), 64'(last_pay[0]));
    drive(2'b00, 2'b00, 1'b0);
    drive(2'b00, 2'b00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
